// File: rtl/zigbee_chip_spreader.sv
// Packs the FIFO's serial bit stream into 4-bit 802.15.4 symbols and emits each symbol's
// 32-chip PN sequence serially at chip rate, with byte-aligned read backpressure.
module zigbee_chip_spreader #(
    parameter int unsigned CHIP_DIV  = 25,
    parameter int unsigned SYM_DEPTH = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tx_en,
    input  logic data_in,
    input  logic iq_rate_in,
    input  logic mem_state_in,
    output logic en_iq,
    output logic chip_out,
    output logic chip_is_q,
    output logic chip_stb,
    output logic busy,
    output logic ovf
);

    localparam int unsigned PtrW = $clog2(SYM_DEPTH);
    localparam int unsigned CntW = $clog2(SYM_DEPTH + 1);
    localparam int unsigned DivW = $clog2(CHIP_DIV);
    localparam logic [31:0] Pn0  = 32'b1101_1001_1100_0011_0101_0010_0010_1110;

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e              state_q, state_d;
    logic                iq_prev_q, iq_prev_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [3:0]          nib_q, nib_d;
    logic                wait_fall_q, wait_fall_d;
    logic                en_iq_q, en_iq_d;
    logic                ovf_q, ovf_d;
    logic [3:0]          sym_buf_q [SYM_DEPTH];
    logic [3:0]          sym_buf_d [SYM_DEPTH];
    logic [PtrW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [3:0]          cur_sym_q, cur_sym_d;
    logic [4:0]          chip_idx_q, chip_idx_d;
    logic [DivW-1:0]     div_q, div_d;

    logic rise, fall, push, push_ok, pop, full, div_last, boundary;
    logic [31:0] pn_w;
    logic unused_mem_state;

    assign unused_mem_state = mem_state_in;

    // MSB of the word is chip 0; rotating the chip sequence right rotates the word right.
    function automatic logic [31:0] pn_word(input logic [3:0] sym);
        logic [63:0] dbl;
        logic [31:0] w;
        dbl = {Pn0, Pn0};
        w   = dbl[{1'b0, sym[2:0], 2'b00} +: 32];
        if (sym[3]) w = w ^ 32'h5555_5555;
        return w;
    endfunction

    assign rise     = iq_rate_in & ~iq_prev_q;
    assign fall     = ~iq_rate_in & iq_prev_q;
    assign push     = rise && (bit_cnt_q[1:0] == 2'b11);
    assign full     = (count_q == CntW'(SYM_DEPTH));
    assign div_last = (state_q == StSend) && (div_q == DivW'(CHIP_DIV - 1));
    assign pop      = (count_q != '0) &&
                      ((state_q == StIdle) || (div_last && chip_idx_q == 5'd31));
    assign push_ok  = push && (!full || pop);
    // Quiet byte boundary: no bit in flight and the 8th-bit strobe has already fallen.
    assign boundary = (bit_cnt_q == 3'd0) && !wait_fall_q && !iq_rate_in && !iq_prev_q;

    always_comb begin
        iq_prev_d   = iq_rate_in;
        bit_cnt_d   = bit_cnt_q;
        nib_d       = nib_q;
        wait_fall_d = wait_fall_q;
        en_iq_d     = en_iq_q;
        ovf_d       = ovf_q;
        sym_buf_d   = sym_buf_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        state_d     = state_q;
        cur_sym_d   = cur_sym_q;
        chip_idx_d  = chip_idx_q;
        div_d       = div_q;

        if (rise) begin
            nib_d[bit_cnt_q[1:0]] = data_in;
            bit_cnt_d             = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) wait_fall_d = 1'b1;
        end else if (fall) begin
            wait_fall_d = 1'b0;
        end

        if (boundary) en_iq_d = tx_en && (count_q <= CntW'(SYM_DEPTH - 2));

        if (push_ok) begin
            sym_buf_d[tail_q] = nib_d;
            tail_d            = tail_q + PtrW'(1);
        end else if (push) begin
            ovf_d = 1'b1;
        end

        if (pop) begin
            cur_sym_d = sym_buf_q[head_q];
            head_d    = head_q + PtrW'(1);
        end

        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    chip_idx_d = 5'd0;
                    div_d      = '0;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (div_last) begin
                    div_d      = '0;
                    chip_idx_d = chip_idx_q + 5'd1;
                    if (chip_idx_q == 5'd31 && !pop) state_d = StIdle;
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            iq_prev_q   <= 1'b0;
            bit_cnt_q   <= 3'd0;
            nib_q       <= 4'd0;
            wait_fall_q <= 1'b0;
            en_iq_q     <= 1'b0;
            ovf_q       <= 1'b0;
            sym_buf_q   <= '{default: '0};
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            cur_sym_q   <= 4'd0;
            chip_idx_q  <= 5'd0;
            div_q       <= '0;
        end else begin
            state_q     <= state_d;
            iq_prev_q   <= iq_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            nib_q       <= nib_d;
            wait_fall_q <= wait_fall_d;
            en_iq_q     <= en_iq_d;
            ovf_q       <= ovf_d;
            sym_buf_q   <= sym_buf_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            cur_sym_q   <= cur_sym_d;
            chip_idx_q  <= chip_idx_d;
            div_q       <= div_d;
        end
    end

    assign pn_w      = pn_word(cur_sym_q);
    assign busy      = (state_q == StSend);
    assign chip_out  = busy & pn_w[5'd31 - chip_idx_q];
    assign chip_is_q = busy & chip_idx_q[0];
    assign chip_stb  = div_last;
    assign en_iq     = en_iq_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_zigbee_chip_spreader.sv
// Scoreboard bench for zigbee_chip_spreader: a FIFO model drives bytes, expected chips are
// queued per symbol and compared against every chip_stb.
module tb_zigbee_chip_spreader;

    localparam int CHIP_DIV  = 25;
    localparam int SYM_DEPTH = 4;

    logic clk = 1'b0;
    logic reset_n, tx_en, data_in, iq_rate_in, mem_state_in;
    logic en_iq, chip_out, chip_is_q, chip_stb, busy, ovf;

    always #5 clk = ~clk;

    zigbee_chip_spreader #(.CHIP_DIV(CHIP_DIV), .SYM_DEPTH(SYM_DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tx_en        (tx_en),
        .data_in      (data_in),
        .iq_rate_in   (iq_rate_in),
        .mem_state_in (mem_state_in),
        .en_iq        (en_iq),
        .chip_out     (chip_out),
        .chip_is_q    (chip_is_q),
        .chip_stb     (chip_stb),
        .busy         (busy),
        .ovf          (ovf)
    );

    typedef struct {
        bit chip;
        bit q;
        int sym;
        int idx;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic bit pn_chip(input int k, input int c);
        logic [0:31] s0;
        bit          v;
        s0 = 32'b11011001110000110101001000101110;
        v  = s0[(c - 4 * (k % 8) + 32) % 32];
        if (k >= 8 && (c % 2) == 1) v = ~v;
        return v;
    endfunction

    task automatic push_sym(input int k);
        for (int c = 0; c < 32; c++) exp_q.push_back('{pn_chip(k, c), (c % 2) == 1, k, c});
    endtask

    // Chip monitor: every strobe pops one expected chip and checks spacing.
    initial begin
        int   run_len;
        exp_t e;
        run_len = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                run_len = 0;
            end else begin
                if (busy) run_len++;
                else run_len = 0;
                if (chip_stb) begin
                    total++;
                    if (run_len != CHIP_DIV) begin
                        bad++;
                        $display("FAIL chip_spacing: got %0d clk, want %0d", run_len, CHIP_DIV);
                    end
                    run_len = 0;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_chip: chip_out=%0b, want no chip", chip_out);
                    end else begin
                        e = exp_q.pop_front();
                        if (chip_out !== e.chip || chip_is_q !== e.q) begin
                            bad++;
                            $display("FAIL chip sym%0d[%0d]: got out=%0b q=%0b, want out=%0b q=%0b",
                                     e.sym, e.idx, chip_out, chip_is_q, e.chip, e.q);
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset();
        reset_n    = 1'b0;
        tx_en      = 1'b0;
        data_in    = 1'b0;
        iq_rate_in = 1'b0;
        repeat (3) @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
    endtask

    // FIFO model: waits for en_iq (unless forced), then shifts a byte out LSB first.
    task automatic send_byte(input logic [7:0] b, input bit force_it, input int drop_bit,
                             output bit held, output bit timed_out);
        int n;
        held      = 1'b1;
        timed_out = 1'b0;
        if (!force_it) begin
            n = 0;
            @(negedge clk);
            while (en_iq !== 1'b1 && n < 5000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 5000) begin
                timed_out = 1'b1;
                return;
            end
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            if (i == drop_bit) tx_en = 1'b0;
            data_in    = b[i];
            iq_rate_in = 1'b1;
            @(negedge clk);
            if (!force_it && en_iq !== 1'b1) held = 1'b0;
            @(posedge clk);
            @(posedge clk);
            iq_rate_in = 1'b0;
            repeat (3) @(posedge clk);
        end
    endtask

    task automatic wait_drain(output bit ok);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        ok = (n < 20000);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tx_en = 1'b0;
        data_in = 1'b0;
        iq_rate_in = 1'b0;
        #1;
        total++;
        if ({en_iq, chip_out, chip_is_q, chip_stb, busy, ovf} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b, want 000000",
                     {en_iq, chip_out, chip_is_q, chip_stb, busy, ovf});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (busy !== 1'b0 || en_iq !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got busy=%b en_iq=%b, want 0 0", busy, en_iq);
        end
        tx_en = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (en_iq !== 1'b1) begin
            bad++;
            $display("FAIL en_iq_raise: got %b, want 1", en_iq);
        end
    endtask

    task automatic test_basic();
        bit held, to, ok;
        do_reset();
        tx_en = 1'b1;
        push_sym(0);
        push_sym(1);
        send_byte(8'h10, 1'b0, -1, held, to);
        total++;
        if (to || !held) begin
            bad++;
            $display("FAIL basic_fetch: got timeout=%0b held=%0b, want 0 1", to, held);
        end
        wait_drain(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL basic_drain: got %0d chips left, want 0", exp_q.size());
        end
    endtask

    task automatic test_sym8();
        bit held, to;
        int n;
        do_reset();
        tx_en = 1'b1;
        push_sym(8);
        push_sym(0);
        send_byte(8'h08, 1'b0, -1, held, to);
        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        total++;
        if (n >= 20000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_fall: got busy=%b left=%0d, want busy=0 left=0", busy, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit held, to, ok;
        do_reset();
        tx_en = 1'b1;
        push_sym(1);
        push_sym(2);
        send_byte(8'h21, 1'b0, -1, held, to);
        push_sym(3);
        push_sym(4);
        send_byte(8'h43, 1'b0, -1, held, to);
        @(negedge clk);
        total++;
        if (en_iq !== 1'b0) begin
            bad++;
            $display("FAIL bp_drop: got en_iq=%b, want 0", en_iq);
        end
        repeat (100) @(negedge clk);
        total++;
        if (en_iq !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold_low: got en_iq=%b, want 0", en_iq);
        end
        push_sym(5);
        push_sym(6);
        send_byte(8'h65, 1'b0, -1, held, to);
        total++;
        if (to || !held) begin
            bad++;
            $display("FAIL bp_reraise: got timeout=%0b held=%0b, want 0 1", to, held);
        end
        wait_drain(ok);
        total++;
        if (!ok || ovf !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain: got ok=%0b ovf=%b, want 1 0", ok, ovf);
        end
    endtask

    task automatic test_tx_en_drop();
        bit held, to, ok;
        do_reset();
        tx_en = 1'b1;
        push_sym(7);
        push_sym(10);
        send_byte(8'hA7, 1'b0, 3, held, to);
        total++;
        if (to || !held) begin
            bad++;
            $display("FAIL txen_hold: got timeout=%0b held=%0b, want 0 1", to, held);
        end
        @(negedge clk);
        total++;
        if (en_iq !== 1'b0) begin
            bad++;
            $display("FAIL txen_clear: got en_iq=%b, want 0", en_iq);
        end
        wait_drain(ok);
        @(negedge clk);
        total++;
        if (!ok || busy !== 1'b0 || en_iq !== 1'b0) begin
            bad++;
            $display("FAIL txen_drain: got ok=%0b busy=%b en_iq=%b, want 1 0 0", ok, busy, en_iq);
        end
    endtask

    task automatic test_overflow();
        bit held, to, ok;
        do_reset();
        tx_en = 1'b1;
        push_sym(1);
        push_sym(2);
        send_byte(8'h21, 1'b0, -1, held, to);
        push_sym(3);
        push_sym(4);
        send_byte(8'h43, 1'b0, -1, held, to);
        @(negedge clk);
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_before: got %b, want 0", ovf);
        end
        push_sym(5);
        send_byte(8'h65, 1'b1, -1, held, to);
        @(negedge clk);
        total++;
        if (ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set: got %b, want 1", ovf);
        end
        wait_drain(ok);
        @(negedge clk);
        total++;
        if (!ok || ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky: got ok=%0b ovf=%b, want 1 1", ok, ovf);
        end
    endtask

    task automatic test_reset_mid();
        bit held, to;
        tx_en = 1'b1;
        push_sym(0);
        push_sym(1);
        send_byte(8'h10, 1'b0, -1, held, to);
        repeat (200) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_busy: got %b, want 1", busy);
        end
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        total++;
        if ({en_iq, chip_out, chip_is_q, chip_stb, busy, ovf} !== 6'b0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got %b, want 000000",
                     {en_iq, chip_out, chip_is_q, chip_stb, busy, ovf});
        end
        tx_en = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (60) @(negedge clk);
        total++;
        if (busy !== 1'b0 || en_iq !== 1'b0) begin
            bad++;
            $display("FAIL mid_idle: got busy=%b en_iq=%b, want 0 0", busy, en_iq);
        end
    endtask

    initial begin
        mem_state_in = 1'b0;
        test_reset();
        test_basic();
        test_sym8();
        test_backpressure();
        test_tx_en_drop();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
